// File: rtl/mips_pkg.sv
// Shared types, widths and helpers for the MIPS instruction-fetch slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

   localparam int ADDR_WIDTH   = 32;
   localparam int INSTR_WITDTH = 32;

   localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // RESET_S is only ever occupied while rst_n is low and for the
   // single cycle that follows its release.
   typedef enum logic [1:0] {
      RESET_S = 2'd0,
      FETCH   = 2'd1,
      EXEC    = 2'd2,
      FAULT   = 2'd3
   } fetch_state_t;

   // Branch displacement: sign-extended 16-bit immediate, in words.
   function automatic logic [ADDR_WIDTH-1:0] branch_offset(input logic [15:0] imm);
      return {{(ADDR_WIDTH-18){imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/mips_ifetch_if.sv
// Instruction-memory read bus between the fetch unit and memory.
// Latency: n/a (wires only).
// Backpressure: memory stalls a request simply by withholding imem_ack.
//
// Signals:
//   imem_req   fetch unit -> memory   read request, held until acked
//   imem_addr  fetch unit -> memory   word-aligned fetch address
//   imem_ack   memory -> fetch unit   response valid; rdata sampled with it
//   imem_rdata memory -> fetch unit   instruction word
interface mips_ifetch_if;

   logic                             imem_req;
   logic [mips_pkg::ADDR_WIDTH-1:0]   imem_addr;
   logic                             imem_ack;
   logic [mips_pkg::INSTR_WITDTH-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/mips_pc_next.sv
// Next-PC selection: jump target, branch target or sequential PC.
// Latency: purely combinational.
// Backpressure: none; the caller decides when next_pc is consumed.
//
// Ports:
//   pc_plus4        in   address following the current instruction
//   instr_idx       in   instr[25:0] (jump index; [15:0] is the branch immediate)
//   pcsrc, jump     in   branch taken / jump; jump wins when both are set
//   tst_target_lsb  in   XORed into the branch target low bits to provoke a
//                        misaligned target; tie to zero in normal use
//   next_pc         out  selected next address (32-bit modulo arithmetic)
//   misaligned      out  next_pc is not word aligned
module mips_pc_next
   import mips_pkg::*;
(
   input  logic [ADDR_WIDTH-1:0] pc_plus4,
   input  logic [25:0]           instr_idx,
   input  logic                  pcsrc,
   input  logic                  jump,
   input  logic [1:0]            tst_target_lsb,
   output logic [ADDR_WIDTH-1:0] next_pc,
   output logic                  misaligned
);

   logic [ADDR_WIDTH-1:0] jump_target;
   logic [ADDR_WIDTH-1:0] branch_target;

   // Jump stays inside the 256 MB region of the delay-slot address.
   assign jump_target   = {pc_plus4[ADDR_WIDTH-1:28], instr_idx, 2'b00};
   assign branch_target = (pc_plus4 + branch_offset(instr_idx[15:0]))
                          ^ {{(ADDR_WIDTH-2){1'b0}}, tst_target_lsb};

   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = jump_target;
      end else if (pcsrc) begin
         next_pc = branch_target;
      end
   end

   assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/mips_ifetch.sv
// Instruction fetch FSM: fetch a word, hold it for execute, then advance the PC.
// Latency: 2 cycles per instruction with a same-cycle ack; +1 per wait cycle.
// Backpressure: stall freezes EXEC; memory backpressure via late imem_ack, bounded by MAX_WAIT.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   imem            instruction memory bus (master side)
//   instr           registered instruction for controller/datapath
//   instr_valid     instr is valid this cycle (EXEC)
//   pc, pc_plus4    address of instr and its successor
//   pcsrc, jump     branch taken / jump, only looked at in EXEC
//   stall           hold EXEC with all registers frozen
//   tst_target_lsb  misaligned-branch-target injection; tie to zero
//   fault           sticky: misaligned next PC or memory timeout
module mips_ifetch
   import mips_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int                    MAX_WAIT = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   mips_ifetch_if.master           imem,
   output logic [INSTR_WITDTH-1:0] instr,
   output logic                    instr_valid,
   output logic [ADDR_WIDTH-1:0]   pc,
   output logic [ADDR_WIDTH-1:0]   pc_plus4,
   input  logic                    pcsrc,
   input  logic                    jump,
   input  logic                    stall,
   input  logic [1:0]              tst_target_lsb,
   output logic                    fault
);

   localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

   fetch_state_t          state;
   fetch_state_t          state_nxt;
   logic [WAIT_W-1:0]     wait_cnt;
   logic [WAIT_W-1:0]     wait_cnt_nxt;
   logic                  load_instr;
   logic                  load_pc;
   logic [ADDR_WIDTH-1:0] next_pc;
   logic                  next_misaligned;

   assign pc_plus4       = pc + 32'd4;
   assign imem.imem_addr = pc;

   mips_pc_next u_pc_next (
      .pc_plus4       (pc_plus4),
      .instr_idx      (instr[25:0]),
      .pcsrc          (pcsrc),
      .jump           (jump),
      .tst_target_lsb (tst_target_lsb),
      .next_pc        (next_pc),
      .misaligned     (next_misaligned)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RESET_S;
      end else begin
         state <= state_nxt;
      end
   end

   // imem_req, instr_valid and fault depend on state alone, so a memory
   // that answers combinationally from imem_req cannot form a loop.
   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = wait_cnt;
      load_instr    = 1'b0;
      load_pc       = 1'b0;
      imem.imem_req = 1'b0;
      instr_valid   = 1'b0;
      fault         = 1'b0;
      case (state)
         RESET_S: begin
            wait_cnt_nxt = '0;
            state_nxt    = FETCH;
         end
         FETCH: begin
            imem.imem_req = 1'b1;
            if (imem.imem_ack) begin
               // An ack on the last allowed cycle still wins over the timeout.
               load_instr = 1'b1;
               state_nxt  = EXEC;
            end else if (wait_cnt == WAIT_LAST) begin
               wait_cnt_nxt = WAIT_MAX;
               state_nxt    = FAULT;
            end else begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         EXEC: begin
            instr_valid = 1'b1;
            if (!stall) begin
               if (next_misaligned) begin
                  // Keep pc pointing at the offending instruction.
                  state_nxt = FAULT;
               end else begin
                  load_pc      = 1'b1;
                  wait_cnt_nxt = '0;
                  state_nxt    = FETCH;
               end
            end
         end
         FAULT: begin
            fault = 1'b1;
         end
         default: begin
            state_nxt = FAULT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         instr    <= '0;
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt_nxt;
         if (load_instr) begin
            instr <= imem.imem_rdata;
         end
         if (load_pc) begin
            pc <= next_pc;
         end
      end
   end

endmodule

// File: tb/tb_mips_ifetch.sv
// Directed bench for mips_ifetch: reset, sequential fetch, branch/jump,
// stall, memory timeout, misaligned target and PC wrap-around.
module tb_mips_ifetch;

   localparam int          MW   = 15;
   localparam logic [31:0] RPC  = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        pcsrc;
   logic        jump;
   logic        stall;
   logic [1:0]  tst_target_lsb;
   logic        fault;

   logic        ack_en;
   logic        ovr_en;
   logic [31:0] ovr_word;

   int vecs = 0;
   int errs = 0;

   mips_ifetch_if bus ();

   // Default memory contents: a recognisable word derived from the address.
   function automatic logic [31:0] seq_word(input logic [31:0] addr);
      return 32'hAC00_0000 ^ addr;
   endfunction

   assign bus.imem_ack   = ack_en & bus.imem_req;
   assign bus.imem_rdata = ovr_en ? ovr_word : seq_word(bus.imem_addr);

   mips_ifetch #(
      .RESET_PC (RPC),
      .MAX_WAIT (MW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem           (bus),
      .instr          (instr),
      .instr_valid    (instr_valid),
      .pc             (pc),
      .pc_plus4       (pc_plus4),
      .pcsrc          (pcsrc),
      .jump           (jump),
      .stall          (stall),
      .tst_target_lsb (tst_target_lsb),
      .fault          (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One FETCH cycle answered immediately with the given word.
   task automatic fetch_word(input logic [31:0] word);
      ovr_word = word;
      ovr_en   = 1'b1;
      ack_en   = 1'b1;
      @(negedge clk);
      ovr_en   = 1'b0;
   endtask

   // One EXEC cycle leaving with the given controller decisions.
   task automatic exec_go(input logic j, input logic b);
      jump  = j;
      pcsrc = b;
      @(negedge clk);
      jump  = 1'b0;
      pcsrc = 1'b0;
   endtask

   task automatic goto_pc(input logic [31:0] target);
      fetch_word({6'b000010, target[27:2]});
      exec_go(1'b1, 1'b0);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; pcsrc = 0; jump = 0; stall = 0; tst_target_lsb = 0;
      ack_en = 1'b1; ovr_en = 0; ovr_word = 0;
      @(negedge clk);
      vecs++; if (pc !== RPC) begin $display("FAIL reset_pc: got %h want %h", pc, RPC); errs++; end
      vecs++; if (pc_plus4 !== RPC + 32'd4) begin $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4, RPC + 32'd4); errs++; end
      vecs++; if (instr !== 32'h0) begin $display("FAIL reset_instr: got %h want 0", instr); errs++; end
      vecs++; if (instr_valid !== 1'b0) begin $display("FAIL reset_instr_valid: got %b want 0", instr_valid); errs++; end
      vecs++; if (bus.imem_req !== 1'b0) begin $display("FAIL reset_imem_req: got %b want 0", bus.imem_req); errs++; end
      vecs++; if (fault !== 1'b0) begin $display("FAIL reset_fault: got %b want 0", fault); errs++; end
      rst_n = 1'b1;
      #1;
      vecs++; if (bus.imem_req !== 1'b0) begin $display("FAIL reset_s_req: got %b want 0", bus.imem_req); errs++; end
      @(negedge clk);
      vecs++; if (bus.imem_req !== 1'b1) begin $display("FAIL first_fetch_req: got %b want 1", bus.imem_req); errs++; end
   endtask

   task automatic test_sequential;
      for (int k = 0; k < 4; k++) begin
         vecs++; if (pc !== 32'(4 * k)) begin $display("FAIL seq_pc[%0d]: got %h want %h", k, pc, 32'(4 * k)); errs++; end
         vecs++; if (instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin $display("FAIL seq_fetch[%0d]: valid=%b req=%b want 0/1", k, instr_valid, bus.imem_req); errs++; end
         vecs++; if (bus.imem_addr !== 32'(4 * k)) begin $display("FAIL seq_addr[%0d]: got %h want %h", k, bus.imem_addr, 32'(4 * k)); errs++; end
         @(negedge clk);
         vecs++; if (instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin $display("FAIL seq_exec[%0d]: valid=%b req=%b want 1/0", k, instr_valid, bus.imem_req); errs++; end
         vecs++; if (instr !== seq_word(32'(4 * k))) begin $display("FAIL seq_instr[%0d]: got %h want %h", k, instr, seq_word(32'(4 * k))); errs++; end
         @(negedge clk);
      end
      vecs++; if (pc !== 32'h10) begin $display("FAIL seq_end_pc: got %h want 00000010", pc); errs++; end
   endtask

   task automatic test_branch;
      goto_pc(32'h40);
      vecs++; if (pc !== 32'h40) begin $display("FAIL goto_40: got %h want 00000040", pc); errs++; end
      fetch_word(32'h1000_0003);
      vecs++; if (pc_plus4 !== 32'h44) begin $display("FAIL beq_pc_plus4: got %h want 00000044", pc_plus4); errs++; end
      exec_go(1'b0, 1'b1);
      vecs++; if (pc !== 32'h50) begin $display("FAIL beq_taken: got %h want 00000050", pc); errs++; end
      goto_pc(32'h40);
      fetch_word(32'h1000_0003);
      exec_go(1'b0, 1'b0);
      vecs++; if (pc !== 32'h44) begin $display("FAIL beq_not_taken: got %h want 00000044", pc); errs++; end
   endtask

   task automatic test_jump_priority;
      goto_pc(32'h0040_0010);
      vecs++; if (pc !== 32'h0040_0010) begin $display("FAIL goto_400010: got %h want 00400010", pc); errs++; end
      fetch_word(32'h0810_0000);
      exec_go(1'b1, 1'b1);
      vecs++; if (pc !== 32'h0040_0000) begin $display("FAIL jump_priority: got %h want 00400000", pc); errs++; end
      vecs++; if (fault !== 1'b0) begin $display("FAIL jump_fault: got %b want 0", fault); errs++; end
   endtask

   task automatic test_stall;
      fetch_word(32'h2222_1111);
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         vecs++; if (instr !== 32'h2222_1111 || pc !== 32'h0040_0000) begin $display("FAIL stall_hold[%0d]: instr=%h pc=%h want 22221111/00400000", i, instr, pc); errs++; end
         vecs++; if (instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin $display("FAIL stall_ctl[%0d]: valid=%b req=%b want 1/0", i, instr_valid, bus.imem_req); errs++; end
         @(negedge clk);
      end
      stall = 1'b0;
      @(negedge clk);
      vecs++; if (pc !== 32'h0040_0004) begin $display("FAIL stall_release_pc: got %h want 00400004", pc); errs++; end
      vecs++; if (instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin $display("FAIL stall_release_ctl: valid=%b req=%b want 0/1", instr_valid, bus.imem_req); errs++; end
   endtask

   task automatic test_ack_last_cycle;
      ack_en = 1'b0;
      repeat (MW - 1) @(negedge clk);
      vecs++; if (fault !== 1'b0 || bus.imem_req !== 1'b1) begin $display("FAIL late_ack_wait: fault=%b req=%b want 0/1", fault, bus.imem_req); errs++; end
      fetch_word(32'h3333_4444);
      vecs++; if (instr_valid !== 1'b1 || fault !== 1'b0) begin $display("FAIL late_ack_exec: valid=%b fault=%b want 1/0", instr_valid, fault); errs++; end
      vecs++; if (instr !== 32'h3333_4444) begin $display("FAIL late_ack_instr: got %h want 33334444", instr); errs++; end
      exec_go(1'b0, 1'b0);
      vecs++; if (pc !== 32'h0040_0008) begin $display("FAIL late_ack_next_pc: got %h want 00400008", pc); errs++; end
   endtask

   task automatic test_reset_mid_fetch;
      ack_en = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      vecs++; if (pc !== RPC || bus.imem_req !== 1'b0) begin $display("FAIL midfetch_reset: pc=%h req=%b want %h/0", pc, bus.imem_req, RPC); errs++; end
      ack_en = 1'b1;
      @(negedge clk);
      vecs++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin $display("FAIL midfetch_late_ack: instr=%h valid=%b want 0/0", instr, instr_valid); errs++; end
      rst_n = 1'b1;
      @(negedge clk);
      vecs++; if (pc !== RPC || bus.imem_req !== 1'b1) begin $display("FAIL midfetch_restart: pc=%h req=%b want %h/1", pc, bus.imem_req, RPC); errs++; end
   endtask

   task automatic test_wrap;
      fetch_word(32'h1000_FFFE);
      exec_go(1'b0, 1'b1);
      vecs++; if (pc !== 32'hFFFF_FFFC) begin $display("FAIL wrap_branch_back: got %h want fffffffc", pc); errs++; end
      fetch_word(32'h0000_0020);
      vecs++; if (pc_plus4 !== 32'h0000_0000) begin $display("FAIL wrap_pc_plus4: got %h want 00000000", pc_plus4); errs++; end
      exec_go(1'b0, 1'b0);
      vecs++; if (pc !== 32'h0000_0000 || fault !== 1'b0) begin $display("FAIL wrap_pc: pc=%h fault=%b want 00000000/0", pc, fault); errs++; end
   endtask

   task automatic test_misaligned;
      goto_pc(32'h30);
      fetch_word(32'h1000_0003);
      tst_target_lsb = 2'b10;
      exec_go(1'b0, 1'b1);
      tst_target_lsb = 2'b00;
      vecs++; if (fault !== 1'b1) begin $display("FAIL misalign_fault: got %b want 1", fault); errs++; end
      vecs++; if (pc !== 32'h30) begin $display("FAIL misalign_pc: got %h want 00000030", pc); errs++; end
      vecs++; if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin $display("FAIL misalign_ctl: req=%b valid=%b want 0/0", bus.imem_req, instr_valid); errs++; end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vecs++; if (fault !== 1'b0 || pc !== RPC) begin $display("FAIL misalign_recover: fault=%b pc=%h want 0/%h", fault, pc, RPC); errs++; end
   endtask

   task automatic test_timeout;
      ack_en = 1'b0;
      repeat (MW - 1) @(negedge clk);
      vecs++; if (fault !== 1'b0) begin $display("FAIL timeout_early: got %b want 0", fault); errs++; end
      @(negedge clk);
      vecs++; if (fault !== 1'b1 || bus.imem_req !== 1'b0) begin $display("FAIL timeout_fault: fault=%b req=%b want 1/0", fault, bus.imem_req); errs++; end
      ack_en = 1'b1;
      repeat (3) @(negedge clk);
      vecs++; if (fault !== 1'b1 || instr_valid !== 1'b0) begin $display("FAIL timeout_sticky: fault=%b valid=%b want 1/0", fault, instr_valid); errs++; end
      rst_n = 1'b0;
      #1;
      vecs++; if (fault !== 1'b0 || pc !== RPC) begin $display("FAIL timeout_reset: fault=%b pc=%h want 0/%h", fault, pc, RPC); errs++; end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vecs++; if (bus.imem_req !== 1'b1 || fault !== 1'b0) begin $display("FAIL timeout_restart: req=%b fault=%b want 1/0", bus.imem_req, fault); errs++; end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_jump_priority();
      test_stall();
      test_ack_last_cycle();
      test_reset_mid_fetch();
      test_wrap();
      test_misaligned();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/mips_ifetch.md
MIPS_IFETCH -- requirements
Module: mips_ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 Parameter MAX_WAIT, default 15, meaning the maximum number of cycles from imem_req to imem_ack before a bus fault.
REQ-003 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address; equals pc.
REQ-007 imem_ack  input  1  memory response valid; imem_rdata is sampled in the same cycle.
REQ-008 imem_rdata  input  INSTR_WITDTH  instruction word returned by memory.
REQ-009 instr  output  INSTR_WITDTH  registered instruction presented to mips_controller and the datapath.
REQ-010 instr_valid  output  1  instr is valid for the current execute cycle.
REQ-011 pc  output  32  address of the instruction currently held in instr.
REQ-012 pc_plus4  output  32  pc + 4, passed to the datapath for branch/link use.
REQ-013 pcsrc  input  1  branch taken, from mips_controller; sampled only in EXEC.
REQ-014 jump  input  1  jump, from mips_controller; sampled only in EXEC.
REQ-015 stall  input  1  holds EXEC; instr, pc and instr_valid remain unchanged.
REQ-016 fault  output  1  sticky error: misaligned next PC or memory timeout.

Function
REQ-017 The FSM SHALL have four states: FETCH, EXEC, FAULT, and RESET_S (reset only).
REQ-018 RESET_S SHALL go to FETCH on the first clock edge after rst_n deasserts.
REQ-019 FETCH: imem_req=1; on imem_ack, instr<=imem_rdata, go to EXEC; otherwise increment wait_cnt.
REQ-020 FETCH: if wait_cnt reaches MAX_WAIT without imem_ack, go to FAULT; an ack in that same cycle takes priority and goes to EXEC.
REQ-021 EXEC: instr_valid=1 and imem_req=0; if stall=1, remain in EXEC with all registers held.
REQ-022 EXEC with stall=0: pc<=next_pc, go to FETCH, clear wait_cnt.
REQ-023 next_pc priority: jump=1 -> {pc_plus4[31:28], instr[25:0], 2'b00}; else pcsrc=1 -> pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4.
REQ-024 All address arithmetic is 32-bit modulo; PC 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 without fault.
REQ-025 If next_pc[1:0] != 2'b00 at EXEC exit, pc SHALL NOT update, and the FSM goes to FAULT.
REQ-026 FAULT: fault=1, imem_req=0, instr_valid=0; exit is only by reset.
REQ-027 Minimum throughput SHALL be one instruction per 2 cycles when imem_ack arrives in the same cycle as imem_req.
REQ-028 imem_req SHALL be combinational from state only, never from imem_ack.

Reset
REQ-029 While rst_n=0: pc=RESET_PC, pc_plus4=RESET_PC+4, instr=0, instr_valid=0, imem_req=0, fault=0, wait_cnt=0, state=RESET_S.
REQ-030 Reset asserted mid-fetch or mid-stall SHALL abandon the transaction immediately; a late imem_ack is ignored.

Structure
REQ-031 Typedef fetch_state_t and constants ADDR_WIDTH=32 and RESET_PC_DEFAULT SHALL be defined in mips_pkg; INSTR_WITDTH is reused from mips_pkg.
REQ-032 Next-PC selection and target arithmetic SHALL be isolated in a combinational sub-module mips_pc_next.
REQ-033 wait_cnt width SHALL be $clog2(MAX_WAIT+1).

Verification
REQ-034 Reset release, memory acks in 0 cycles, stall=0, sequential words -> pc sequence 0,4,8,C with instr_valid every second cycle.
REQ-035 At pc=0x40, instr=0x1000_0003 (BEQ), pcsrc=1 -> next pc=0x50; with pcsrc=0 -> next pc=0x44.
REQ-036 At pc=0x0040_0010, instr=0x0810_0000 (J), jump=1 and pcsrc=1 together -> next pc=0x0040_0000, because jump has priority.
REQ-037 stall=1 for 5 EXEC cycles -> instr, pc and instr_valid=1 are stable, imem_req=0; on release, a single advance.
REQ-038 imem_ack withheld for MAX_WAIT cycles -> fault=1 and imem_req=0; a subsequent rst_n pulse restores pc=RESET_PC and fault=0.
REQ-039 BEQ with offset producing target 0x0000_0042 (injected via a misaligned-target test hook) -> fault=1 and pc unchanged; separately, pc=0xFFFF_FFFC sequential -> pc=0x0000_0000 with fault=0.
